// File: rtl/mem_arbiter_pkg.sv
// Shared types and default parameters for the memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_CLIENTS = 3;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SEL_W       = DEF_DATA_W / 8;
    localparam int DEF_PRIO_CLIENT = 1;
    localparam int DEF_TIMEOUT     = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side and memory-side signal bundle of the arbiter.
// slave: the arbiter's view; master: the clients/memory environment view.
interface mem_arbiter_if #(
    parameter int NUM_CLIENTS = arb_pkg::DEF_NUM_CLIENTS,
    parameter int ADDR_W      = arb_pkg::DEF_ADDR_W,
    parameter int DATA_W      = arb_pkg::DEF_DATA_W,
    parameter int SEL_W       = DATA_W / 8
);
    localparam int ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [NUM_CLIENTS-1:0]        cl_write;
    logic [NUM_CLIENTS-1:0]        cl_read;
    logic [NUM_CLIENTS*ADDR_W-1:0] cl_adr;
    logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata;
    logic [NUM_CLIENTS*SEL_W-1:0]  cl_sel;
    logic                          prio_reserve;
    logic [NUM_CLIENTS-1:0]        cl_ack;
    logic                          cl_err;
    logic [DATA_W-1:0]             cl_rdata;
    logic [ID_W-1:0]               grant_id;
    logic                          arb_busy;
    logic                          write_to_mem;
    logic                          read_to_mem;
    logic [ADDR_W-1:0]             adr_to_mem;
    logic [DATA_W-1:0]             data_to_mem;
    logic [SEL_W-1:0]              sel_to_mem;
    logic [DATA_W-1:0]             data_from_mem;
    logic                          mem_busy;

    modport slave (
        input  cl_write, cl_read, cl_adr, cl_wdata, cl_sel, prio_reserve,
        input  data_from_mem, mem_busy,
        output cl_ack, cl_err, cl_rdata, grant_id, arb_busy,
        output write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem
    );

    modport master (
        output cl_write, cl_read, cl_adr, cl_wdata, cl_sel, prio_reserve,
        output data_from_mem, mem_busy,
        input  cl_ack, cl_err, cl_rdata, grant_id, arb_busy,
        input  write_to_mem, read_to_mem, adr_to_mem, data_to_mem, sel_to_mem
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Rotating first-requester search: lowest requester at or after ptr_i,
// wrapping around to index 0 when none is found above the pointer.
module rr_picker #(
    parameter int NUM_CLIENTS = arb_pkg::DEF_NUM_CLIENTS,
    parameter int ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [ID_W-1:0]        ptr_i,
    output logic [NUM_CLIENTS-1:0] gnt_o,
    output logic                   valid_o
);

    // Two passes: first the upper segment [ptr, N), then the wrap from 0.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!valid_o && req_i[i] && (i >= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                valid_o  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!valid_o && req_i[i]) begin
                gnt_o[i] = 1'b1;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-client memory arbiter: fixed-priority client plus round-robin
// among the rest, one outstanding memory transaction with a WAIT timeout.
//
//  state | meaning
//  IDLE  | sampling requests, no memory activity
//  REQ   | one-cycle strobe of the granted request to memory
//  WAIT  | strobes low, fields held, waiting for mem_busy=0 or timeout
//  RESP  | one-cycle ack (and err on timeout) to the grantee
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SEL_W       = DATA_W / 8,
    parameter int PRIO_CLIENT = DEF_PRIO_CLIENT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          nRst,
    mem_arbiter_if.slave  bus
);

    localparam int ID_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [NUM_CLIENTS-1:0] req_vec;
    logic [NUM_CLIENTS-1:0] pick_oh;
    logic                   pick_valid;
    logic [NUM_CLIENTS-1:0] win_oh;
    logic                   win_valid;
    logic [ID_W-1:0]        win_idx;
    logic                   win_wr;
    logic                   win_rd;
    logic [ADDR_W-1:0]      win_adr;
    logic [DATA_W-1:0]      win_wdata;
    logic [SEL_W-1:0]       win_sel;

    assign req_vec = bus.cl_read | bus.cl_write;

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ID_W        (ID_W)
    ) u_picker (
        .req_i   (req_vec),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_oh),
        .valid_o (pick_valid)
    );

    // Winner selection: priority client overrides; reserve blocks the rest.
    always_comb begin
        win_oh    = '0;
        win_valid = 1'b0;
        if (req_vec[PRIO_CLIENT]) begin
            win_oh[PRIO_CLIENT] = 1'b1;
            win_valid           = 1'b1;
        end else if (!bus.prio_reserve) begin
            win_oh    = pick_oh;
            win_valid = pick_valid;
        end
    end

    // Mux the winner's request fields; a simultaneous write beats the read.
    always_comb begin
        win_idx   = '0;
        win_wr    = 1'b0;
        win_rd    = 1'b0;
        win_adr   = '0;
        win_wdata = '0;
        win_sel   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (win_oh[i]) begin
                win_idx   = ID_W'(i);
                win_wr    = bus.cl_write[i];
                win_rd    = bus.cl_read[i] & ~bus.cl_write[i];
                win_adr   = bus.cl_adr[i*ADDR_W +: ADDR_W];
                win_wdata = bus.cl_wdata[i*DATA_W +: DATA_W];
                win_sel   = bus.cl_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    // State and datapath registers; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d    = REQ;
                    grant_id_d = win_idx;
                    wr_d       = win_wr;
                    rd_d       = win_rd;
                    adr_d      = win_adr;
                    wdata_d    = win_wdata;
                    sel_d      = win_sel;
                end
            end
            REQ: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (!bus.mem_busy) begin
                    state_d = RESP;
                    rdata_d = bus.data_from_mem;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                // The priority client is served outside the rotation.
                if (grant_id_q != ID_W'(PRIO_CLIENT)) begin
                    rr_ptr_d = (grant_id_q == ID_W'(NUM_CLIENTS - 1)) ?
                               '0 : grant_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears them without a clock.
    always_comb begin
        bus.arb_busy     = (state_q != IDLE);
        bus.grant_id     = grant_id_q;
        bus.write_to_mem = (state_q == REQ) & wr_q;
        bus.read_to_mem  = (state_q == REQ) & rd_q;
        bus.adr_to_mem   = '0;
        bus.data_to_mem  = '0;
        bus.sel_to_mem   = '0;
        if (state_q == REQ || state_q == WAIT) begin
            bus.adr_to_mem  = adr_q;
            bus.data_to_mem = wdata_q;
            bus.sel_to_mem  = sel_q;
        end
        bus.cl_ack   = '0;
        bus.cl_err   = 1'b0;
        bus.cl_rdata = '0;
        if (state_q == RESP) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                bus.cl_ack[i] = (grant_id_q == ID_W'(i));
            end
            bus.cl_err   = err_q;
            bus.cl_rdata = rdata_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with 3 clients, priority client 1, TIMEOUT 8.
module tb_mem_arbiter;

    logic clk;
    logic nRst;
    int   vectors;
    int   miscompares;
    int   n;

    mem_arbiter_if #(
        .NUM_CLIENTS (3),
        .ADDR_W      (32),
        .DATA_W      (32),
        .SEL_W       (4)
    ) bus ();

    mem_arbiter #(
        .NUM_CLIENTS (3),
        .ADDR_W      (32),
        .DATA_W      (32),
        .SEL_W       (4),
        .PRIO_CLIENT (1),
        .TIMEOUT     (8)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until an ack pulse is visible; n counts cycles from the call.
    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (bus.cl_ack == 3'b000 && cycles < 40);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        nRst         = 1'b0;
        bus.cl_write = '0;
        bus.cl_read  = '0;
        bus.cl_adr   = '0;
        bus.cl_wdata = '0;
        bus.cl_sel   = '0;
        bus.prio_reserve  = 1'b0;
        bus.data_from_mem = '0;
        bus.mem_busy      = 1'b0;
        bus.cl_adr[0*32 +: 32]   = 32'h0000_0010;
        bus.cl_adr[1*32 +: 32]   = 32'h0000_0014;
        bus.cl_adr[2*32 +: 32]   = 32'h0000_0020;
        bus.cl_wdata[2*32 +: 32] = 32'hCAFE_0002;
        bus.cl_sel[2*4 +: 4]     = 4'h5;

        // Reset state
        tick();
        tick();
        check("rst_ack",   64'(bus.cl_ack), 64'h0);
        check("rst_busy",  64'(bus.arb_busy), 64'h0);
        check("rst_gid",   64'(bus.grant_id), 64'h0);
        check("rst_rdata", 64'(bus.cl_rdata), 64'h0);
        check("rst_adr",   64'(bus.adr_to_mem), 64'h0);
        nRst = 1'b1;
        tick();

        // Single read by client 0, memory ready immediately
        bus.data_from_mem = 32'hDEAD_BEEF;
        bus.cl_read[0]    = 1'b1;
        tick();
        check("rd_req_rstrobe", 64'(bus.read_to_mem), 64'h1);
        check("rd_req_wstrobe", 64'(bus.write_to_mem), 64'h0);
        check("rd_req_adr",     64'(bus.adr_to_mem), 64'h10);
        check("rd_req_busy",    64'(bus.arb_busy), 64'h1);
        tick();
        check("rd_wait_rstrobe", 64'(bus.read_to_mem), 64'h0);
        check("rd_wait_adr",     64'(bus.adr_to_mem), 64'h10);
        check("rd_wait_ack",     64'(bus.cl_ack), 64'h0);
        tick();
        check("rd_resp_ack",   64'(bus.cl_ack), 64'h1);
        check("rd_resp_rdata", 64'(bus.cl_rdata), 64'hDEADBEEF);
        check("rd_resp_err",   64'(bus.cl_err), 64'h0);
        check("rd_resp_adr",   64'(bus.adr_to_mem), 64'h0);
        bus.cl_read[0] = 1'b0;
        tick();
        check("rd_after_ack",  64'(bus.cl_ack), 64'h0);
        check("rd_after_busy", 64'(bus.arb_busy), 64'h0);

        // Round robin between clients 0 and 2 from rr_ptr=0
        nRst = 1'b0;
        #2;
        nRst = 1'b1;
        bus.cl_read[0] = 1'b1;
        bus.cl_read[2] = 1'b1;
        wait_ack(n);
        check("rr_ack0", 64'(bus.cl_ack), 64'h1);
        check("rr_lat0", 64'(n), 64'd3);
        wait_ack(n);
        check("rr_ack1", 64'(bus.cl_ack), 64'h4);
        check("rr_gid1", 64'(bus.grant_id), 64'h2);
        wait_ack(n);
        check("rr_ack2", 64'(bus.cl_ack), 64'h1);
        wait_ack(n);
        check("rr_ack3", 64'(bus.cl_ack), 64'h4);
        bus.cl_read = '0;
        tick();
        tick();

        // All three request: priority client first, rr_ptr untouched by it
        bus.cl_read = 3'b111;
        wait_ack(n);
        check("prio_ack0", 64'(bus.cl_ack), 64'h2);
        bus.cl_read[1] = 1'b0;
        wait_ack(n);
        check("prio_ack1", 64'(bus.cl_ack), 64'h1);
        bus.cl_read[0] = 1'b0;
        wait_ack(n);
        check("prio_ack2", 64'(bus.cl_ack), 64'h4);
        bus.cl_read = '0;
        tick();
        tick();

        // Reserve: client 2 (read+write) blocked until reserve drops
        bus.prio_reserve = 1'b1;
        bus.cl_write[2]  = 1'b1;
        bus.cl_read[2]   = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("rsv_busy", 64'(bus.arb_busy), 64'h0);
        check("rsv_ack",  64'(bus.cl_ack), 64'h0);
        bus.cl_read[1] = 1'b1;
        wait_ack(n);
        check("rsv_ack1", 64'(bus.cl_ack), 64'h2);
        bus.cl_read[1]   = 1'b0;
        bus.prio_reserve = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.write_to_mem || bus.read_to_mem) && n < 40);
        check("wr_wins_w",   64'(bus.write_to_mem), 64'h1);
        check("wr_wins_r",   64'(bus.read_to_mem), 64'h0);
        check("wr_data",     64'(bus.data_to_mem), 64'hCAFE0002);
        check("wr_sel",      64'(bus.sel_to_mem), 64'h5);
        check("wr_gid",      64'(bus.grant_id), 64'h2);
        wait_ack(n);
        check("wr_ack", 64'(bus.cl_ack), 64'h4);
        bus.cl_write = '0;
        bus.cl_read  = '0;
        tick();
        tick();

        // Timeout: mem_busy stuck high for 8 WAIT cycles
        bus.mem_busy      = 1'b1;
        bus.data_from_mem = 32'h1234_5678;
        bus.cl_read[0]    = 1'b1;
        wait_ack(n);
        check("to_lat",   64'(n), 64'd10);
        check("to_ack",   64'(bus.cl_ack), 64'h1);
        check("to_err",   64'(bus.cl_err), 64'h1);
        check("to_rdata", 64'(bus.cl_rdata), 64'h0);
        bus.cl_read[0] = 1'b0;
        tick();
        check("to_err_clr", 64'(bus.cl_err), 64'h0);
        tick();

        // Busy released after a few WAIT cycles, before the timeout
        bus.cl_read[2] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus.mem_busy = 1'b0;
        wait_ack(n);
        check("late_lat",   64'(n), 64'd1);
        check("late_err",   64'(bus.cl_err), 64'h0);
        check("late_rdata", 64'(bus.cl_rdata), 64'h12345678);
        bus.cl_read[2] = 1'b0;
        tick();
        tick();

        // Reset during WAIT: immediate clear, no ack, regrant after release
        bus.mem_busy      = 1'b1;
        bus.data_from_mem = 32'h0BAD_F00D;
        bus.cl_read[2]    = 1'b1;
        tick();
        tick();
        tick();
        check("mid_busy", 64'(bus.arb_busy), 64'h1);
        check("mid_gid",  64'(bus.grant_id), 64'h2);
        nRst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.arb_busy), 64'h0);
        check("mid_rst_gid",  64'(bus.grant_id), 64'h0);
        check("mid_rst_adr",  64'(bus.adr_to_mem), 64'h0);
        tick();
        tick();
        check("mid_rst_ack",  64'(bus.cl_ack), 64'h0);
        nRst         = 1'b1;
        bus.mem_busy = 1'b0;
        wait_ack(n);
        check("regrant_lat",   64'(n), 64'd3);
        check("regrant_ack",   64'(bus.cl_ack), 64'h4);
        check("regrant_rdata", 64'(bus.cl_rdata), 64'h0BADF00D);
        bus.cl_read = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_CLIENTS, 3, requesters; ADDR_W, 32, address width; DATA_W, 32, data width; SEL_W, DATA_W/8, byte-select width; PRIO_CLIENT, 1, fixed-priority client index; TIMEOUT, 255, max WAIT cycles before error.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 system clock
- nRst in 1 asynchronous active-low reset
- cl_write in NUM_CLIENTS per-client write request
- cl_read in NUM_CLIENTS per-client read request
- cl_adr in NUM_CLIENTS*ADDR_W flattened addresses; client i at [i*ADDR_W +: ADDR_W]
- cl_wdata in NUM_CLIENTS*DATA_W flattened write data
- cl_sel in NUM_CLIENTS*SEL_W flattened byte selects
- prio_reserve in 1 blocks new non-priority grants
- cl_ack out NUM_CLIENTS one-hot completion pulse
- cl_err out 1 timeout flag, valid with cl_ack
- cl_rdata out DATA_W shared read data, valid with cl_ack
- grant_id out $clog2(NUM_CLIENTS) current or last grantee
- arb_busy out 1 high when state is not IDLE
- write_to_mem, read_to_mem out 1 memory strobes
- adr_to_mem out ADDR_W; data_to_mem out DATA_W; sel_to_mem out SEL_W
- data_from_mem in DATA_W; mem_busy in 1
REQ-003 Clock and reset SHALL be one clock, clk; reset nRst, asynchronous, active-low.

Function
REQ-004 Client i requests when cl_read[i] or cl_write[i] is high; it SHALL hold request fields stable until its cl_ack pulse.
REQ-005 States SHALL be IDLE, REQ, WAIT, RESP.
REQ-006 In IDLE with any request, winner SHALL be PRIO_CLIENT if requesting, else the first requester at or after rr_ptr, wrapping modulo NUM_CLIENTS; next state REQ.
REQ-007 While prio_reserve=1, only PRIO_CLIENT SHALL be grantable; other requests leave state IDLE.
REQ-008 At the grant edge, winner write/read/adr/wdata/sel and grant_id SHALL be registered; if read and write are both high, the registered read strobe SHALL be 0 and the write SHALL win.
REQ-009 REQ SHALL last exactly one cycle, with registered fields on the memory outputs; next state WAIT.
REQ-010 In WAIT, memory address/data/sel SHALL hold and strobes SHALL be 0; mem_busy=0 SHALL move to RESP; minimum WAIT is one cycle.
REQ-011 The WAIT cycle counter SHALL reach TIMEOUT with mem_busy=1 -> RESP with cl_err=1.
REQ-012 In RESP, cl_ack[grant_id] SHALL be 1 for exactly one cycle, cl_rdata=data_from_mem captured at the WAIT exit edge (0 on timeout), and rr_ptr=(grant_id+1) mod NUM_CLIENTS; next state IDLE.
REQ-013 Requests SHALL NOT be sampled in REQ/WAIT/RESP; the minimum request-to-ack latency is 3 cycles (IDLE sample, REQ, WAIT, ack in RESP).
REQ-014 Granting PRIO_CLIENT SHALL NOT modify rr_ptr.
REQ-015 Outside REQ/WAIT, all memory outputs SHALL be 0; outside RESP, cl_ack and cl_err SHALL be 0.
REQ-016 The timeout counter SHALL be TIMEOUT-sized, clear on entering WAIT and not wrap.

Reset
REQ-017 nRst=0 SHALL immediately force IDLE, rr_ptr=0, grant_id=0, counter=0, cl_ack=0, cl_err=0, cl_rdata=0, all memory outputs 0 and arb_busy=0, including mid-transaction; an aborted transaction SHALL NOT be acked.

Structure
REQ-018 Package arb_pkg SHALL hold the arb_state_t enum (IDLE, REQ, WAIT, RESP) and the default-parameter constants.
REQ-019 Sub-module rr_picker (combinational: request vector and pointer in, one-hot winner and valid out) SHALL implement the rotating search.

Verification (NUM_CLIENTS=3, PRIO_CLIENT=1, TIMEOUT=8)
REQ-020 Client 0 read adr 0x10, mem_busy low, data_from_mem 0xDEADBEEF -> read_to_mem one cycle, cl_ack=001 on the 3rd cycle, cl_rdata=0xDEADBEEF.
REQ-021 Clients 0 and 2 requesting continuously, rr_ptr=0 -> grant order 0,2,0,2, one ack per transaction.
REQ-022 Clients 0, 1 and 2 requesting together -> client 1 first, then 0 (rr_ptr unchanged by client 1's grant).
REQ-023 prio_reserve=1, client 2 requesting -> no grant; client 1 then requests -> client 1 granted.
REQ-024 mem_busy held high -> after 8 WAIT cycles, cl_ack pulse with cl_err=1 and cl_rdata=0.
REQ-025 nRst low during WAIT -> all outputs 0 immediately, no ack; after release, the held request is regranted from IDLE.
